// File: rtl/interval_timer_ctrl.sv
// Start/stop/pause interval timer: IDLE/RUN/PAUSE FSM driving a wrap-around tick counter.
// Define TIMER_PRESCALE_EN to divide the tick rate by PRESCALE; otherwise every RUN cycle ticks.
module interval_timer_ctrl #(
  parameter int N        = 7,
  parameter int PRESCALE = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         one_shot,
  input  logic [N-1:0] period,
  output logic         count_enb,
  output logic [N-1:0] count,
  output logic         done,
  output logic         busy,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t       state_reg;
  logic [N-1:0] count_reg;
  logic [N-1:0] period_reg;
  logic         done_reg;
  logic         busy_reg;
  logic [N-1:0] last_count;
  logic         tick_hit;
  logic         tick;

  if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_prescale
    $error("interval_timer_ctrl: PRESCALE must be within 2..256");
  end

  // period_reg==0 wraps to all-ones, which is exactly the 2^N-tick terminal count
  assign last_count = period_reg - N'(1);

`ifdef TIMER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] presc_reg;

  assign tick_hit = (presc_reg == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg <= '0;
    end else if (state_reg != RUN) begin
      // Hold in PAUSE; IDLE keeps it cleared so every launch starts a fresh tick interval
      if (state_reg == IDLE) presc_reg <= '0;
    end else if (!stop) begin
      presc_reg <= tick_hit ? '0 : presc_reg + PW'(1);
    end
  end
`else
  assign tick_hit = 1'b1;
`endif

  // The strobe is qualified by stop so a pausing cycle never advances the counter
  assign tick      = (state_reg == RUN) && !stop && tick_hit;
  assign count_enb = tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      period_reg <= '0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && !stop) begin
            period_reg <= period;
            count_reg  <= '0;
            state_reg  <= RUN;
            busy_reg   <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_reg <= PAUSE;
          end else if (tick) begin
            if (count_reg == last_count) begin
              count_reg <= '0;
              done_reg  <= 1'b1;
              if (one_shot) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end
            end else begin
              count_reg <= count_reg + N'(1);
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            state_reg <= IDLE;
            count_reg <= '0;
            busy_reg  <= 1'b0;
          end else if (start) begin
            state_reg <= RUN;
          end
        end
        default: begin
          state_reg <= IDLE;
          count_reg <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_reg;
  assign done  = done_reg;
  assign busy  = busy_reg;
  assign state = state_reg;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl (default build, no prescaler):
// directed vector table, hand-written corner sequences, then random traffic against a behavioural model.
module tb_interval_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       one_shot = 1'b0;
  logic [6:0] period = '0;
  logic       count_enb;
  logic [6:0] count;
  logic       done;
  logic       busy;
  logic [1:0] state;

  interval_timer_ctrl #(.N(7), .PRESCALE(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .one_shot  (one_shot),
    .period    (period),
    .count_enb (count_enb),
    .count     (count),
    .done      (done),
    .busy      (busy),
    .state     (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode 0=idle 1=run 2=pause, plain integer counting modulo P
  int m_mode  = 0;
  int m_count = 0;
  int m_len   = 0;
  bit m_done  = 0;
  bit m_enb   = 0;
  logic a_enb;

  typedef struct {
    bit         r;
    bit         st;
    bit         sp;
    bit         os;
    logic [6:0] per;
    bit         e_enb;
    int         e_count;
    bit         e_done;
    int         e_state;
  } vec_t;

  vec_t vecs [0:21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit st, input bit sp, input bit os, input logic [6:0] per);
    reset = r; start = st; stop = sp; one_shot = os; period = per;
    #3;
    a_enb = count_enb;
    m_enb = (m_mode == 1) && !sp;
    @(posedge clk);
    #1;
    m_done = 0;
    if (r) begin
      m_mode = 0; m_count = 0; m_len = 0;
    end else if (m_mode == 0) begin
      if (st && !sp) begin
        m_len = (per == 0) ? 128 : int'(per);
        m_count = 0;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (sp) m_mode = 2;
      else begin
        m_count = (m_count + 1) % m_len;
        if (m_count == 0) begin
          m_done = 1;
          if (os) m_mode = 0;
        end
      end
    end else begin
      if (sp) begin
        m_mode = 0; m_count = 0;
      end else if (st) m_mode = 1;
    end
    $display("cyc r=%0b st=%0b sp=%0b os=%0b per=%0d -> enb=%0b count=%0d done=%0b busy=%0b state=%0d",
             r, st, sp, os, per, a_enb, count, done, busy, state);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_enb"},   32'(a_enb), 32'(m_enb));
    chk({tag, "_count"}, 32'(count), 32'(m_count));
    chk({tag, "_done"},  32'(done),  32'(m_done));
    chk({tag, "_state"}, 32'(state), 32'(m_mode));
    chk({tag, "_busy"},  32'(busy),  32'(m_mode != 0));
  endtask

  initial begin
    //            r st sp os per  enb cnt dn st
    vecs[0]  = '{1, 0, 0, 0, 7'd0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 1, 7'd3, 0, 0, 0, 1};
    vecs[2]  = '{0, 0, 0, 1, 7'd6, 1, 1, 0, 1};
    vecs[3]  = '{0, 0, 0, 1, 7'd6, 1, 2, 0, 1};
    vecs[4]  = '{0, 0, 0, 1, 7'd6, 1, 0, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 7'd0, 0, 0, 0, 0};
    vecs[6]  = '{0, 1, 1, 0, 7'd5, 0, 0, 0, 0};
    vecs[7]  = '{0, 1, 0, 0, 7'd5, 0, 0, 0, 1};
    vecs[8]  = '{0, 0, 0, 0, 7'd5, 1, 1, 0, 1};
    vecs[9]  = '{0, 0, 0, 0, 7'd5, 1, 2, 0, 1};
    vecs[10] = '{0, 1, 1, 0, 7'd5, 0, 2, 0, 2};
    vecs[11] = '{0, 0, 0, 0, 7'd5, 0, 2, 0, 2};
    vecs[12] = '{0, 1, 0, 0, 7'd5, 0, 2, 0, 1};
    vecs[13] = '{0, 1, 0, 0, 7'd5, 1, 3, 0, 1};
    vecs[14] = '{0, 0, 0, 0, 7'd5, 1, 4, 0, 1};
    vecs[15] = '{0, 0, 0, 0, 7'd5, 1, 0, 1, 1};
    vecs[16] = '{0, 0, 1, 1, 7'd5, 0, 0, 0, 2};
    vecs[17] = '{0, 0, 1, 0, 7'd5, 0, 0, 0, 0};
    vecs[18] = '{0, 1, 0, 0, 7'd2, 0, 0, 0, 1};
    vecs[19] = '{0, 0, 0, 0, 7'd2, 1, 1, 0, 1};
    vecs[20] = '{1, 1, 0, 0, 7'd2, 1, 0, 0, 0};
    vecs[21] = '{0, 1, 0, 0, 7'd4, 0, 0, 0, 1};

    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 7'd0);

    // Directed vector table
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].r, vecs[i].st, vecs[i].sp, vecs[i].os, vecs[i].per);
      chk($sformatf("vec%0d_enb", i),   32'(a_enb), 32'(vecs[i].e_enb));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d_done", i),  32'(done),  32'(vecs[i].e_done));
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].e_state));
      chk($sformatf("vec%0d_busy", i),  32'(busy),  32'(vecs[i].e_state != 0));
    end

    // Full wrap: period 0 means 128 ticks
    drive(1, 0, 0, 0, 7'd0);
    check_model("wrap_rst");
    drive(0, 1, 0, 0, 7'd0);
    check_model("wrap_launch");
    for (int i = 0; i < 127; i++) begin
      drive(0, 0, 0, 0, 7'd9);
      check_model("wrap_run");
    end
    chk("wrap_max", 32'(count), 32'd127);
    drive(0, 0, 0, 0, 7'd9);
    chk("wrap_zero", 32'(count), 32'd0);
    chk("wrap_done", 32'(done), 32'd1);

    // Pause for 10 cycles at count 2 after relaunch at period 5
    drive(0, 0, 1, 0, 7'd0);
    drive(0, 0, 1, 0, 7'd0);
    check_model("abort");
    drive(0, 1, 0, 0, 7'd5);
    drive(0, 0, 0, 0, 7'd5);
    drive(0, 0, 0, 0, 7'd5);
    drive(0, 0, 1, 0, 7'd5);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 7'd5);
      chk("pause_hold_count", 32'(count), 32'd2);
      chk("pause_hold_state", 32'(state), 32'd2);
    end
    drive(0, 1, 0, 0, 7'd5);
    drive(0, 0, 0, 0, 7'd5);
    chk("resume_count", 32'(count), 32'd3);

    // Randomised traffic against the model
    drive(1, 0, 0, 0, 7'd0);
    check_model("rnd_rst");
    for (int i = 0; i < 3000; i++) begin
      bit         r, st, sp, os;
      logic [6:0] per;
      r   = ($urandom_range(0, 99) == 0);
      st  = ($urandom_range(0, 3) == 0);
      sp  = ($urandom_range(0, 9) == 0);
      os  = ($urandom_range(0, 3) == 0);
      per = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 9));
      drive(r, st, sp, os, per);
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
